sine_addr_gen: RTL and testbench
================================

SINE_ADDR_GEN -- requirements
Module: sine_addr_gen

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 8: width of the generated ROM address.
REQ-002 Parameter ACC_WIDTH, default 16: phase accumulator width; must be >= ADDRESS_WIDTH.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  pulse that starts generation from IDLE.
REQ-006 stop  input  1  pulse that aborts generation and returns to IDLE.
REQ-007 mode  input  1  0 = continuous, 1 = burst; sampled only on start.
REQ-008 en  input  1  advance enable; low pauses the accumulator while running.
REQ-009 incr  input  ACC_WIDTH  phase step, sampled live on every advance.
REQ-010 burst_len  input  16  number of advances per burst; sampled on start.
REQ-011 offset  input  ADDRESS_WIDTH  phase offset for addr2; present only with SINE_OFFSET_EN.
REQ-012 addr  output  ADDRESS_WIDTH  ROM address, acc[ACC_WIDTH-1 -: ADDRESS_WIDTH].
REQ-013 addr2  output  ADDRESS_WIDTH  second ROM address; present only with SINE_OFFSET_EN.
REQ-014 addr_valid  output  1  high for the cycle following each advance.
REQ-015 data_valid  output  1  addr_valid delayed one cycle, aligned to the 1-cycle ROM read.
REQ-016 busy  output  1  high when state is RUN.
REQ-017 done  output  1  one-cycle pulse at burst completion.

Function
REQ-018 FSM states: IDLE, RUN, DONE; state, acc, and the burst counter are registered.
REQ-019 IDLE: start=1 and stop=0 -> RUN. Load cnt=burst_len and latch mode.
REQ-020 RUN: an advance occurs at each edge with en=1: acc <= acc + incr, modulo 2^ACC_WIDTH.
REQ-021 RUN with en=0: acc, cnt, and addr hold; addr_valid <= 0.
REQ-022 Burst mode: each advance decrements cnt; the advance with cnt==1 moves to DONE.
REQ-023 Burst mode with burst_len=0: start goes straight to DONE with no advance.
REQ-024 Continuous mode: RUN persists until stop; cnt is ignored.
REQ-025 DONE: done=1 for exactly one cycle; then -> IDLE unconditionally; acc holds its final value.
REQ-026 stop=1 in any state -> IDLE next edge with no advance on that edge; stop beats start when both are asserted.
REQ-027 start while RUN or DONE is ignored.
REQ-028 A new start from IDLE does not clear acc; phase continues from the last value.
REQ-029 addr_valid <= 1 exactly on edges where an advance occurs, else 0; data_valid <= addr_valid.
REQ-030 busy is combinational from state (state==RUN).

Reset
REQ-031 rst_n low asynchronously forces: state=IDLE, acc=0, cnt=0, addr=0, addr2=0 (if present), addr_valid=0, data_valid=0, done=0.
REQ-032 Reset asserted mid-burst aborts with no done pulse; after release the block waits in IDLE for start.

Configuration
REQ-033 Macro SINE_OFFSET_EN defined: the offset port and the addr2 port exist.
REQ-034 With SINE_OFFSET_EN, addr2 = addr + offset modulo 2^ADDRESS_WIDTH, registered alongside addr (same cycle).
REQ-035 Macro SINE_OFFSET_EN undefined: the offset and addr2 ports and their logic are absent; all other behaviour is identical.

Verification
REQ-036 Reset, then mode=1, incr=0x0100, burst_len=4, start pulse -> addr 0x01,0x02,0x03,0x04 on consecutive cycles; done one cycle later; data_valid high for 4 cycles, lagging addr_valid by 1.
REQ-037 Wrap-around: acc=0xFF00 (reached via bursts), incr=0x0100, one advance -> addr=0x00, no stall.
REQ-038 Fractional step: incr=0x0080, continuous, en=1 for 6 cycles -> addr 0x00,0x01,0x01,0x02,0x02,0x03; stop -> IDLE, busy=0.
REQ-039 Pause and control conflicts, in order:
- en=0 for 3 cycles mid-burst (burst_len=5) -> addr and cnt hold, addr_valid=0; total advances still 5.
- start and stop asserted together in IDLE -> stays IDLE.
REQ-040 SINE_OFFSET_EN, offset=0x40, addr reaching 0xF0 -> addr2=0x30 in the same cycle.
REQ-041 rst_n pulled low asynchronously mid-burst between edges -> all outputs 0 immediately, no done; start after release begins from addr 0x00.

Source files
------------

// File: rtl/sine_addr_gen.sv
// Phase-accumulator address generator for a sine ROM, with continuous and burst modes.
// Define SINE_OFFSET_EN to add the offset input and a second, phase-shifted address (addr2).
module sine_addr_gen #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int ACC_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     mode,
  input  logic                     en,
  input  logic [ACC_WIDTH-1:0]     incr,
  input  logic [15:0]              burst_len,
`ifdef SINE_OFFSET_EN
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [ADDRESS_WIDTH-1:0] addr2,
`endif
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic                     addr_valid,
  output logic                     data_valid,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_reg;
  logic [ACC_WIDTH-1:0]   acc_reg;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [15:0]            cnt_reg;
  logic                   mode_reg;

  assign acc_next = acc_reg + incr;
  // The address is the top slice of the registered accumulator, so it is updated on the same edge as acc.
  assign addr     = acc_reg[ACC_WIDTH-1 -: ADDRESS_WIDTH];
  assign busy     = (state_reg == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      mode_reg   <= 1'b0;
      addr_valid <= 1'b0;
      data_valid <= 1'b0;
      done       <= 1'b0;
`ifdef SINE_OFFSET_EN
      addr2      <= '0;
`endif
    end else begin
      addr_valid <= 1'b0;
      data_valid <= addr_valid;
      done       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !stop) begin
            mode_reg <= mode;
            cnt_reg  <= burst_len;
            // A zero-length burst completes without ever advancing.
            state_reg <= (mode && burst_len == 16'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_reg <= IDLE;
          end else if (en) begin
            acc_reg    <= acc_next;
            addr_valid <= 1'b1;
`ifdef SINE_OFFSET_EN
            addr2      <= acc_next[ACC_WIDTH-1 -: ADDRESS_WIDTH] + offset;
`endif
            if (mode_reg) begin
              cnt_reg <= cnt_reg - 16'd1;
              if (cnt_reg == 16'd1)
                state_reg <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done      <= 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sine_addr_gen.sv
// Directed bench for sine_addr_gen: a cycle table for burst/wrap/pause/conflict cases,
// then hand-written sequences for async reset, fractional continuous stepping and the offset address.
module tb_sine_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, mode, en;
  logic [15:0] incr, burst_len;
  logic [7:0]  addr;
  logic        addr_valid, data_valid, busy, done;
`ifdef SINE_OFFSET_EN
  logic [7:0]  offset;
  logic [7:0]  addr2;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sine_addr_gen #(.ADDRESS_WIDTH(8), .ACC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .en(en),
    .incr(incr), .burst_len(burst_len),
`ifdef SINE_OFFSET_EN
    .offset(offset), .addr2(addr2),
`endif
    .addr(addr), .addr_valid(addr_valid), .data_valid(data_valid), .busy(busy), .done(done)
  );

  typedef struct {
    logic        start, stop, en;
    logic [15:0] incr, burst_len;
    logic [7:0]  exp_addr;
    logic        exp_av, exp_dv, exp_busy, exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic p, logic e, logic [15:0] i, logic [15:0] bl,
                              logic [7:0] a, logic av, logic dv, logic b, logic d);
    vec_t v;
    v.start = s; v.stop = p; v.en = e; v.incr = i; v.burst_len = bl;
    v.exp_addr = a; v.exp_av = av; v.exp_dv = dv; v.exp_busy = b; v.exp_done = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Packed view {addr, addr_valid, data_valid, busy, done}.
  function automatic logic [11:0] outs();
    return {addr, addr_valid, data_valid, busy, done};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 0; stop = 0; mode = 1; en = 1;
    incr = 16'h0100; burst_len = 16'd4;
`ifdef SINE_OFFSET_EN
    offset = 8'h40;
`endif
    #11;
    check("reset_outputs", {20'd0, outs()}, 32'd0);
    rst_n = 1'b1;
    step();

    //        st p  en incr      len    addr  av dv busy done
    // Burst of 4 with incr 0x0100.
    vecs.push_back(mk(1, 0, 1, 16'h0100, 16'd4, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd4, 8'h01, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd4, 8'h02, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd4, 8'h03, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd4, 8'h04, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd4, 8'h04, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd4, 8'h04, 0, 0, 0, 0));
    // Single advance of 0xFB00 lands acc on 0xFF00, then wrap to 0x0000.
    vecs.push_back(mk(1, 0, 1, 16'hFB00, 16'd1, 8'h04, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'hFB00, 16'd1, 8'hFF, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd1, 8'hFF, 0, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 16'h0100, 16'd1, 8'hFF, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd1, 8'h00, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd1, 8'h00, 0, 1, 0, 1));
    // Burst of 5 with a 3-cycle pause; a start with len 9 mid-run must be ignored.
    vecs.push_back(mk(1, 0, 1, 16'h0100, 16'd5, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd5, 8'h01, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 16'h0100, 16'd9, 8'h02, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0100, 16'd5, 8'h02, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0100, 16'd5, 8'h02, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0100, 16'd5, 8'h02, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd5, 8'h03, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd5, 8'h04, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd5, 8'h05, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd5, 8'h05, 0, 1, 0, 1));
    // start and stop together in IDLE: stays IDLE.
    vecs.push_back(mk(1, 1, 1, 16'h0100, 16'd5, 8'h05, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd5, 8'h05, 0, 0, 0, 0));
    // Zero-length burst: straight to DONE, then done pulse, no advance.
    vecs.push_back(mk(1, 0, 1, 16'h0100, 16'd0, 8'h05, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd0, 8'h05, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 16'h0100, 16'd0, 8'h05, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; stop = vecs[i].stop; en = vecs[i].en;
      incr = vecs[i].incr; burst_len = vecs[i].burst_len; mode = 1'b1;
      step();
      check($sformatf("vec%0d {addr,av,dv,busy,done}", i), {20'd0, outs()},
            {20'd0, vecs[i].exp_addr, vecs[i].exp_av, vecs[i].exp_dv,
             vecs[i].exp_busy, vecs[i].exp_done});
    end

    // Async reset mid-burst, between edges.
    start = 1; stop = 0; mode = 1; en = 1; incr = 16'h0100; burst_len = 16'd4;
    step();
    start = 0;
    step();
    step();
    check("pre_reset_addr", {24'd0, addr}, 32'h07);
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {20'd0, outs()}, 32'd0);
    step();
    step();
    check("no_done_after_reset", {20'd0, outs()}, 32'd0);
    #2 rst_n = 1'b1;
    start = 1;
    step();
    start = 0;
    check("restart_addr_busy", {20'd0, outs()}, {20'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    check("restart_first_adv", {24'd0, addr}, 32'h01);
    stop = 1;
    step();
    stop = 0;
    check("stop_busy", {31'd0, busy}, 32'd0);

    // Fractional continuous stepping from a freshly reset accumulator.
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mode = 0; incr = 16'h0080; en = 1; start = 1;
    step();
    start = 0;
    begin
      logic [7:0] frac_exp [6];
      frac_exp = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03};
      for (int k = 0; k < 6; k++) begin
        step();
        check($sformatf("frac_adv%0d addr", k), {24'd0, addr}, {24'd0, frac_exp[k]});
      end
    end
    stop = 1;
    step();
    stop = 0;
    check("frac_stop {addr,av,busy}", {22'd0, addr, addr_valid, busy}, {22'd0, 8'h03, 1'b0, 1'b0});

    // acc 0x0300 + 0xED00 = 0xF000 -> addr 0xF0, addr2 = 0xF0 + 0x40 = 0x30.
    mode = 0; incr = 16'hED00; start = 1;
    step();
    start = 0;
    step();
    check("offset_case_addr", {24'd0, addr}, 32'hF0);
`ifdef SINE_OFFSET_EN
    check("offset_case_addr2", {24'd0, addr2}, 32'h30);
`endif
    stop = 1;
    step();
    stop = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
